// File: rtl/tx_word_arbiter_pkg.sv
// Shared definitions for the two-requester word-to-byte UART feeder:
// FSM encoding, default word size and byte-counter sizing.
package tx_word_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        WAIT = 2'b10
    } state_t;

    localparam int NUM_BYTES_DEF = 4;

    // Counter must hold 0..num_bytes-1; never narrower than one bit.
    function automatic int byte_cnt_w(input int num_bytes);
        return (num_bytes > 2) ? $clog2(num_bytes) : 1;
    endfunction

endpackage

// File: rtl/tx_word_arbiter_rr.sv
// Two-way round-robin selector: a lone valid always wins, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_arbiter2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_valid0 & (~i_valid1 |  i_last_grant);
    assign o_grant[1] = i_valid1 & (~i_valid0 | ~i_last_grant);

endmodule

// File: rtl/tx_word_arbiter.sv
// Accepts whole words from two requesters and streams each one MSB-first,
// one byte per Tx_Done handshake, to a byte-wide UART transmitter.
module tx_word_arbiter
    import tx_word_arbiter_pkg::*;
#(
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter int DATA_W    = 8 * NUM_BYTES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0_valid_in,
    input  logic [DATA_W-1:0] Req0_data_in,
    output logic              Req0_ready_out,
    input  logic              Req1_valid_in,
    input  logic [DATA_W-1:0] Req1_data_in,
    output logic              Req1_ready_out,
    output logic              Tx_DV_out,
    output logic [7:0]        Tx_Byte_out,
    input  logic              Tx_Done_in,
    output logic              Busy_out,
    output logic              Grant_out
);

    localparam int              CNT_W    = byte_cnt_w(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_word;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic              r_grant;
    logic              r_last_grant;
    logic [7:0]        r_tx_byte;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_done_wait;
    logic              w_last_byte;
    logic [DATA_W-1:0] w_byte_src;
    logic [CNT_W-1:0]  w_byte_idx;
    logic [7:0]        w_next_byte;

    rr_arbiter2 u_rr (
        .i_valid0     (Req0_valid_in),
        .i_valid1     (Req1_valid_in),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_last_byte = (r_byte_cnt == LAST_IDX);
    assign Busy_out    = (r_state != IDLE);
    assign Grant_out   = r_grant;
    assign Tx_Byte_out = r_tx_byte;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        w_next_state   = r_state;
        Req0_ready_out = 1'b0;
        Req1_ready_out = 1'b0;
        Tx_DV_out      = 1'b0;
        w_accept       = 1'b0;
        w_done_wait    = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low during reset so no handshake completes that the
                // registers would then discard.
                Req0_ready_out = w_grant[0] & ~RST;
                Req1_ready_out = w_grant[1] & ~RST;
                w_accept       = (Req0_valid_in & Req0_ready_out) |
                                 (Req1_valid_in & Req1_ready_out);
                if (w_accept) w_next_state = SEND;
            end
            SEND: begin
                Tx_DV_out    = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (Tx_Done_in) begin
                    w_done_wait  = 1'b1;
                    w_next_state = w_last_byte ? IDLE : SEND;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The byte register is loaded on the edge that enters SEND, so it is
    // valid with the strobe and holds until the next load.
    always_comb begin
        w_byte_src  = w_accept ? (w_grant[1] ? Req1_data_in : Req0_data_in) : r_word;
        w_byte_idx  = w_accept ? '0 : r_byte_cnt + 1'b1;
        w_next_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_byte_idx == CNT_W'(i)) w_next_byte = w_byte_src[DATA_W-1-8*i -: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tx_byte    <= '0;
        end else if (w_accept) begin
            r_word     <= w_byte_src;
            r_byte_cnt <= '0;
            r_grant    <= w_grant[1];
            r_tx_byte  <= w_next_byte;
        end else if (w_done_wait) begin
            if (w_last_byte) begin
                r_last_grant <= r_grant;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_tx_byte  <= w_next_byte;
            end
        end
    end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Directed bench for tx_word_arbiter: single word, contention, spurious
// Done, reset mid-word and back-to-back streaming, with hand-computed bytes.
module tb_tx_word_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Req0_valid_in = 1'b0;
    logic [31:0] Req0_data_in  = '0;
    logic        Req0_ready_out;
    logic        Req1_valid_in = 1'b0;
    logic [31:0] Req1_data_in  = '0;
    logic        Req1_ready_out;
    logic        Tx_DV_out;
    logic [7:0]  Tx_Byte_out;
    logic        Tx_Done_in;
    logic        Busy_out;
    logic        Grant_out;

    logic        resp_en   = 1'b0;
    int          resp_dly  = 1;
    logic        resp_done = 1'b0;
    logic        man_done  = 1'b0;
    int          cyc       = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;

    logic [7:0]  dv_byte[$];
    logic        dv_grant[$];
    int          dv_cyc[$];

    assign Tx_Done_in = resp_done | man_done;

    tx_word_arbiter dut (
        .CLK            (CLK),
        .RST            (RST),
        .Req0_valid_in  (Req0_valid_in),
        .Req0_data_in   (Req0_data_in),
        .Req0_ready_out (Req0_ready_out),
        .Req1_valid_in  (Req1_valid_in),
        .Req1_data_in   (Req1_data_in),
        .Req1_ready_out (Req1_ready_out),
        .Tx_DV_out      (Tx_DV_out),
        .Tx_Byte_out    (Tx_Byte_out),
        .Tx_Done_in     (Tx_Done_in),
        .Busy_out       (Busy_out),
        .Grant_out      (Grant_out)
    );

    initial forever #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    // Byte monitor: logs every strobe with its cycle number and owner.
    initial forever begin
        @(negedge CLK);
        if (Tx_DV_out === 1'b1) begin
            dv_byte.push_back(Tx_Byte_out);
            dv_grant.push_back(Grant_out);
            dv_cyc.push_back(cyc);
        end
    end

    // UART model: pulses Done resp_dly cycles after each strobe it sees.
    initial begin : responder
        int cd;
        cd = 0;
        forever begin
            @(negedge CLK);
            resp_done = 1'b0;
            if (RST) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd = cd - 1;
                    if (cd == 0) resp_done = 1'b1;
                end
                if (Tx_DV_out === 1'b1 && resp_en) cd = resp_dly;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int k = 0;
        while (Busy_out !== 1'b0 && k < max_cyc) begin
            step();
            k++;
        end
        check({tag, "_idle_timeout"}, 32'(Busy_out), 32'd0);
    endtask

    task automatic wait_dvs(input string tag, input int n, input int max_cyc);
        int k = 0;
        while (dv_byte.size() < n && k < max_cyc) begin
            step();
            k++;
        end
        check({tag, "_dv_timeout"}, 32'(dv_byte.size() >= n), 32'd1);
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    function automatic void clear_log();
        dv_byte.delete();
        dv_grant.delete();
        dv_cyc.delete();
    endfunction

    initial begin
        logic [31:0] t2_words[3];
        int          t1_last;
        t2_words = '{32'h1122_3344, 32'h5566_7788, 32'h1122_3344};

        // Reset state
        @(posedge CLK);
        #1;
        check("rst_dv",    32'(Tx_DV_out),      32'd0);
        check("rst_byte",  32'(Tx_Byte_out),    32'd0);
        check("rst_busy",  32'(Busy_out),       32'd0);
        check("rst_grant", 32'(Grant_out),      32'd0);
        check("rst_rdy0",  32'(Req0_ready_out), 32'd0);
        step();
        RST = 1'b0;
        step();

        // Single word from requester 0, Done three cycles after each strobe
        resp_en  = 1'b1;
        resp_dly = 3;
        clear_log();
        Req0_valid_in = 1'b1;
        Req0_data_in  = 32'hA1B2_C3D4;
        #1;
        check("t1_rdy0", 32'(Req0_ready_out), 32'd1);
        check("t1_rdy1", 32'(Req1_ready_out), 32'd0);
        step();
        Req0_valid_in = 1'b0;
        Req0_data_in  = 32'hFFFF_FFFF;
        check("t1_dv_first",   32'(Tx_DV_out),   32'd1);
        check("t1_byte_first", 32'(Tx_Byte_out), 32'hA1);
        check("t1_busy",       32'(Busy_out),    32'd1);
        check("t1_grant",      32'(Grant_out),   32'd0);
        wait_idle("t1", 80);
        check("t1_dv_count", 32'(dv_byte.size()), 32'd4);
        for (int i = 0; i < 4 && i < dv_byte.size(); i++) begin
            check($sformatf("t1_byte%0d", i), 32'(dv_byte[i]), 32'(byte_of(32'hA1B2_C3D4, i)));
            if (i > 0) check($sformatf("t1_gap%0d", i), 32'(dv_cyc[i] - dv_cyc[i-1]), 32'd4);
        end
        t1_last = (dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size()-1] : 0;
        check("t1_busy_fall", 32'(cyc - t1_last), 32'd4);

        // Contention straight out of reset: R0, then R1, then R0 again
        RST = 1'b1;
        resp_dly = 1;
        clear_log();
        step();
        RST = 1'b0;
        Req0_valid_in = 1'b1;
        Req0_data_in  = 32'h1122_3344;
        Req1_valid_in = 1'b1;
        Req1_data_in  = 32'h5566_7788;
        #1;
        check("t2_rdy0", 32'(Req0_ready_out), 32'd1);
        check("t2_rdy1", 32'(Req1_ready_out), 32'd0);
        step();
        step();
        check("t2_wait_rdy0", 32'(Req0_ready_out), 32'd0);
        check("t2_wait_rdy1", 32'(Req1_ready_out), 32'd0);
        wait_dvs("t2", 9, 100);
        Req0_valid_in = 1'b0;
        Req1_valid_in = 1'b0;
        wait_idle("t2", 100);
        check("t2_dv_count", 32'(dv_byte.size()), 32'd12);
        for (int i = 0; i < 12 && i < dv_byte.size(); i++) begin
            check($sformatf("t2_byte%0d", i), 32'(dv_byte[i]), 32'(byte_of(t2_words[i/4], i%4)));
            check($sformatf("t2_grant%0d", i), 32'(dv_grant[i]), 32'((i/4) == 1));
        end

        // Spurious Done in IDLE and in SEND must not advance anything
        resp_en  = 1'b0;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("t3_idle_busy", 32'(Busy_out),  32'd0);
        check("t3_idle_dv",   32'(Tx_DV_out), 32'd0);
        clear_log();
        Req1_valid_in = 1'b1;
        Req1_data_in  = 32'h0102_0304;
        #1;
        check("t3_rdy1", 32'(Req1_ready_out), 32'd1);
        step();
        Req1_valid_in = 1'b0;
        man_done = 1'b1;
        check("t3_send_dv",    32'(Tx_DV_out),   32'd1);
        check("t3_send_byte",  32'(Tx_Byte_out), 32'h01);
        check("t3_send_grant", 32'(Grant_out),   32'd1);
        step();
        man_done = 1'b0;
        check("t3_wait_dv",   32'(Tx_DV_out), 32'd0);
        check("t3_wait_busy", 32'(Busy_out),  32'd1);
        step();
        step();
        check("t3_stall_dv",    32'(dv_byte.size()), 32'd1);
        check("t3_stall_byte",  32'(Tx_Byte_out),    32'h01);
        resp_en  = 1'b1;
        resp_dly = 1;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("t3_second_dv",   32'(Tx_DV_out),   32'd1);
        check("t3_second_byte", 32'(Tx_Byte_out), 32'h02);
        wait_idle("t3", 40);
        check("t3_dv_count", 32'(dv_byte.size()), 32'd4);
        for (int i = 0; i < 4 && i < dv_byte.size(); i++)
            check($sformatf("t3_byte%0d", i), 32'(dv_byte[i]), 32'(byte_of(32'h0102_0304, i)));

        // Reset after the second strobe of a word aborts it
        clear_log();
        resp_dly = 2;
        Req0_valid_in = 1'b1;
        Req0_data_in  = 32'hCAFE_BABE;
        step();
        Req0_valid_in = 1'b0;
        wait_dvs("t4", 2, 20);
        step();
        RST = 1'b1;
        #1;
        check("t4_rst_dv",   32'(Tx_DV_out),   32'd0);
        check("t4_rst_byte", 32'(Tx_Byte_out), 32'd0);
        check("t4_rst_busy", 32'(Busy_out),    32'd0);
        check("t4_rst_grant", 32'(Grant_out),  32'd0);
        step();
        step();
        RST = 1'b0;
        check("t4_no_third_dv", 32'(dv_byte.size()), 32'd2);
        Req0_valid_in = 1'b1;
        Req0_data_in  = 32'h0F1E_2D3C;
        Req1_valid_in = 1'b1;
        Req1_data_in  = 32'h5A6B_7C8D;
        #1;
        check("t4_rdy0", 32'(Req0_ready_out), 32'd1);
        check("t4_rdy1", 32'(Req1_ready_out), 32'd0);
        step();
        Req0_valid_in = 1'b0;
        Req1_valid_in = 1'b0;
        wait_idle("t4", 60);
        check("t4_dv_count", 32'(dv_byte.size()), 32'd6);
        for (int i = 2; i < 6 && i < dv_byte.size(); i++) begin
            check($sformatf("t4_byte%0d", i), 32'(dv_byte[i]), 32'(byte_of(32'h0F1E_2D3C, i-2)));
            check($sformatf("t4_grant%0d", i), 32'(dv_grant[i]), 32'd0);
        end

        // Back-to-back words from R1 with Done on WAIT entry
        clear_log();
        resp_dly = 1;
        Req1_valid_in = 1'b1;
        Req1_data_in  = 32'h1020_3040;
        wait_dvs("t5", 8, 60);
        Req1_valid_in = 1'b0;
        wait_idle("t5", 40);
        check("t5_dv_count", 32'(dv_byte.size()), 32'd8);
        for (int i = 0; i < 8 && i < dv_byte.size(); i++) begin
            check($sformatf("t5_byte%0d", i), 32'(dv_byte[i]), 32'(byte_of(32'h1020_3040, i%4)));
            check($sformatf("t5_grant%0d", i), 32'(dv_grant[i]), 32'd1);
            if (i > 0)
                check($sformatf("t5_gap%0d", i), 32'(dv_cyc[i] - dv_cyc[i-1]), (i == 4) ? 32'd3 : 32'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_word_arbiter.md
TX_WORD_ARBITER -- requirements
Module: tx_word_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 4: bytes per word, legal range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 8*NUM_BYTES: word width; any other value is illegal.
REQ-003 The block SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port Req0_valid_in  in  1  requester 0 has a word to send.
REQ-006 The block SHALL have port Req0_data_in  in  DATA_W  requester 0 word.
REQ-007 The block SHALL have port Req0_ready_out  out  1  requester 0 word accepted this cycle when valid.
REQ-008 The block SHALL have ports Req1_valid_in, Req1_data_in, Req1_ready_out, identical to requester 0 but for requester 1.
REQ-009 The block SHALL have port Tx_DV_out  out  1  one-cycle byte strobe to the UART transmitter.
REQ-010 The block SHALL have port Tx_Byte_out  out  8  byte to transmit.
REQ-011 The block SHALL have port Tx_Done_in  in  1  one-cycle pulse, UART finished current byte.
REQ-012 The block SHALL have port Busy_out  out  1  high when not IDLE.
REQ-013 The block SHALL have port Grant_out  out  1  index of requester owning the current or last word.

Function
REQ-014 The block SHALL implement FSM states IDLE, SEND and WAIT.
REQ-015 In IDLE, Req<i>_ready_out SHALL be high only for the requester selected by the arbiter; it SHALL be low in SEND and WAIT.
REQ-016 Arbitration SHALL be round-robin: if only one valid, grant it; if both valid, grant the one not granted last.
REQ-017 Accept SHALL occur when valid and ready are high in the same cycle; the block then latches the word, sets Grant_out, clears byte_cnt and goes to SEND.
REQ-018 SEND SHALL last one cycle, with Tx_DV_out=1 and Tx_Byte_out = word byte byte_cnt, MSB first (byte 0 = bits DATA_W-1..DATA_W-8); the next state is WAIT.
REQ-019 Tx_Byte_out SHALL remain stable from SEND until the next SEND or accept.
REQ-020 In WAIT with Tx_Done_in=1: if byte_cnt == NUM_BYTES-1, go to IDLE and record Grant_out as last granted; else increment byte_cnt and go to SEND.
REQ-021 Tx_Done_in SHALL be ignored in IDLE and SEND.
REQ-022 Latency from accept to first Tx_DV_out SHALL be 1 cycle; from Tx_Done_in to the next Tx_DV_out within a word, 1 cycle.
REQ-023 After the final Tx_Done_in there SHALL be at least one IDLE cycle before the next accept; the gap from the final Tx_Done_in to the next word's first Tx_DV_out SHALL be 2 cycles minimum.
REQ-024 Exactly NUM_BYTES Tx_DV_out pulses SHALL be issued per accepted word; a word SHALL never be interleaved with another.
REQ-025 Requester inputs changing during SEND/WAIT SHALL have no effect on the word in flight.

Reset
REQ-026 On RST high, immediately: state=IDLE, Tx_DV_out=0, Tx_Byte_out=0, Busy_out=0, Grant_out=0, byte_cnt=0, word register=0.
REQ-027 On reset, last-granted SHALL be set to 1, so requester 0 wins the first contention.
REQ-028 Reset mid-word SHALL abort the word, with no further Tx_DV_out pulses; Req<i>_ready_out SHALL follow IDLE arbitration from the first cycle after release.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, SEND=2'b01, WAIT=2'b10), the NUM_BYTES default and the byte-count width function.
REQ-030 Round-robin selection SHALL be one sub-module, rr_arbiter2 (inputs: two valids and last-grant; outputs: one-hot grant), purely combinational.
REQ-031 The remainder (FSM, word register, byte counter, byte mux) SHALL reside in tx_word_arbiter.

Verification
REQ-032 Single word: Req0 sends 0xA1B2C3D4, Tx_Done 3 cycles after each DV -> bytes A1,B2,C3,D4, exactly 4 DV pulses, Grant_out=0, Busy_out falls after the 4th Done.
REQ-033 Contention: both valid at the first cycle after reset (R0=0x11223344, R1=0x55667788) -> R0 word sent fully, then R1; then with both valid again, R0 sent next.
REQ-034 Spurious Done: Tx_Done_in pulsed in IDLE and in SEND -> no state change, byte_cnt unchanged.
REQ-035 Reset mid-word: RST asserted after the 2nd DV of 0xCAFEBABE -> outputs reach their reset values immediately, no 3rd DV; a new word afterwards starts at its MSB.
REQ-036 Back-to-back: R1 held valid continuously, Done returned the same cycle as WAIT entry -> DV spacing 2 cycles within a word and 3 cycles across words.
